// File: rtl/serial_sig_analyzer.sv
// Serial signature analyzer: folds a serial response stream into an n-bit
// internal-XOR signature register and compares it against a golden value.
// Optional build macro SSA_ABORT_EN adds an abort input that cancels a run.
module serial_sig_analyzer #(
    parameter int n  = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          sin,
    input  logic          sin_valid,
    input  logic [n-1:0]  poly,
    input  logic [n-1:0]  seed,
    input  logic [CW-1:0] length,
    input  logic [n-1:0]  golden,
`ifdef SSA_ABORT_EN
    input  logic          abort,
`endif
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [n-1:0]  signature
);

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    state_t        state, state_next;
    logic [n-1:0]  sig, sig_next, golden_q, golden_next, step_sig;
    logic [CW-1:0] cnt, cnt_next;
    logic          pass_next, abort_hit, fb;

`ifdef SSA_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // One compaction step, same shift/XOR structure as the pattern generator.
    always_comb begin
        fb = sig[0] ^ sin;
        step_sig = '0;
        step_sig[n-1] = fb;
        for (int i = 0; i < n-1; i++) begin
            step_sig[i] = sig[i+1] ^ (fb & poly[i]);
        end
    end

    always_comb begin
        state_next  = state;
        sig_next    = sig;
        cnt_next    = cnt;
        golden_next = golden_q;
        pass_next   = pass;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    sig_next    = seed;
                    cnt_next    = length;
                    golden_next = golden;
                    pass_next   = 1'b0;
                    state_next  = (length != '0) ? RUN : CHECK;
                end
            end
            RUN: begin
                if (abort_hit) begin
                    pass_next  = 1'b0;
                    state_next = IDLE;
                end else if (sin_valid) begin
                    sig_next = step_sig;
                    cnt_next = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_next = CHECK;
                    end
                end
            end
            CHECK: begin
                if (abort_hit) begin
                    pass_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    pass_next  = (sig == golden_q);
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sig      <= '0;
            cnt      <= '0;
            golden_q <= '0;
            pass     <= 1'b0;
        end else begin
            state    <= state_next;
            sig      <= sig_next;
            cnt      <= cnt_next;
            golden_q <= golden_next;
            pass     <= pass_next;
        end
    end

    assign busy      = (state == RUN) || (state == CHECK);
    assign done      = (state == DONE);
    assign signature = sig;

endmodule
